// File: rtl/buffer_mem_if.sv
// buffer_mem_if -- bundle of every non-clock signal of the load/store buffer.
//   issue_*    : op offered by dispatch (valid, opcode, tag, Vj/Qj, Vk/Qk)
//   full       : buffer cannot take another op
//   cdb_*      : common data bus broadcast snooped by the buffer
//   A/data/W/opcode_out/nova : request towards memory (nova = one-cycle strobe)
//   mem_out/V_pronto         : memory read data and done pulse
//   res_*      : load result broadcast
//   err        : sticky memory-timeout flag
// Modport slave is the buffer's view; master is the surrounding system's view.
interface buffer_mem_if;
   logic        issue_valid;
   logic [1:0]  issue_opcode;
   logic [3:0]  issue_tag;
   logic [15:0] issue_Vj;
   logic [3:0]  issue_Qj;
   logic [15:0] issue_Vk;
   logic [3:0]  issue_Qk;
   logic        full;
   logic        cdb_valid;
   logic [3:0]  cdb_tag;
   logic [15:0] cdb_value;
   logic [7:0]  A;
   logic [15:0] data;
   logic        W;
   logic [1:0]  opcode_out;
   logic        nova;
   logic [15:0] mem_out;
   logic        V_pronto;
   logic        res_valid;
   logic [3:0]  res_tag;
   logic [15:0] res_value;
   logic        err;

   modport slave (
      input  issue_valid, issue_opcode, issue_tag, issue_Vj, issue_Qj,
             issue_Vk, issue_Qk, cdb_valid, cdb_tag, cdb_value, mem_out, V_pronto,
      output full, A, data, W, opcode_out, nova, res_valid, res_tag, res_value, err
   );

   modport master (
      output issue_valid, issue_opcode, issue_tag, issue_Vj, issue_Qj,
             issue_Vk, issue_Qk, cdb_valid, cdb_tag, cdb_value, mem_out, V_pronto,
      input  full, A, data, W, opcode_out, nova, res_valid, res_tag, res_value, err
   );
endinterface

// File: rtl/buffer_mem.sv
// buffer_mem -- in-order load/store buffer feeding a single memory port.
// Ops queue in a circular FIFO of DEPTH entries, snoop the CDB for missing
// operands, and are sent to memory one at a time from the head. Loads broadcast
// their result on res_*; stores complete silently.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : buffer_mem_if.slave (issue, full, cdb, memory request/response, result, err)
// Parameter DEPTH: entry count, power of two in 2..16.
// Optional feature macro BUFFER_MEM_TIMEOUT_EN: when defined, 8 WAIT cycles
// without V_pronto raise sticky err and re-issue the same head op.
module buffer_mem #(
   parameter int DEPTH = 4
) (
   input logic          clock,
   input logic          reset,
   buffer_mem_if.slave  bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [1:0]  op;
      logic [3:0]  tag;
      logic [15:0] vj;
      logic [3:0]  qj;
      logic [15:0] vk;
      logic [3:0]  qk;
   } entry_t;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_BCAST} state_t;

   entry_t           ent_q [DEPTH];
   entry_t           ent_d [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   state_t           state_q, state_d;

   logic [7:0]  A_q, A_d;
   logic [15:0] data_q, data_d;
   logic        W_q, W_d;
   logic [1:0]  op_q, op_d;
   logic        nova_q, nova_d;
   logic [15:0] rdata_q, rdata_d;
   logic        res_valid_q, res_valid_d;
   logic [3:0]  res_tag_q, res_tag_d;
   logic [15:0] res_value_q, res_value_d;

   entry_t new_e;
   entry_t hd;
   logic   full, accept, pop, hd_ready, timeout;

   assign full     = (cnt_q == CW'(DEPTH));
   assign accept   = bus.issue_valid && !full;
   assign hd       = ent_q[head_q];
   assign hd_ready = vld_q[head_q] && (hd.qj == 4'd0) && (!hd.op[0] || hd.qk == 4'd0);
   // Head leaves on store completion or after its load result is broadcast.
   assign pop      = (state_q == S_WAIT && bus.V_pronto && hd.op[0]) || (state_q == S_BCAST);

   // Timeout watchdog on the WAIT state
`ifdef BUFFER_MEM_TIMEOUT_EN
   logic [3:0] wcnt_q, wcnt_d;
   logic       err_q;

   assign timeout = (state_q == S_WAIT) && !bus.V_pronto && (wcnt_q == 4'd7);
   assign wcnt_d  = ((state_q == S_WAIT) && !bus.V_pronto && !timeout) ? wcnt_q + 4'd1 : 4'd0;

   always_ff @(posedge clock) begin
      if (reset) begin
         wcnt_q <= '0;
         err_q  <= 1'b0;
      end else begin
         wcnt_q <= wcnt_d;
         err_q  <= err_q | timeout;
      end
   end
   assign bus.err = err_q;
`else
   assign timeout = 1'b0;
   assign bus.err = 1'b0;
`endif

   // Incoming op, with same-cycle CDB forwarding; loads never wait on Qk.
   always_comb begin
      new_e.op  = bus.issue_opcode;
      new_e.tag = bus.issue_tag;
      new_e.vj  = bus.issue_Vj;
      new_e.qj  = bus.issue_Qj;
      new_e.vk  = bus.issue_Vk;
      new_e.qk  = bus.issue_opcode[0] ? bus.issue_Qk : 4'd0;
      if (bus.cdb_valid && new_e.qj != 4'd0 && new_e.qj == bus.cdb_tag) begin
         new_e.vj = bus.cdb_value;
         new_e.qj = 4'd0;
      end
      if (bus.cdb_valid && new_e.qk != 4'd0 && new_e.qk == bus.cdb_tag) begin
         new_e.vk = bus.cdb_value;
         new_e.qk = 4'd0;
      end
   end

   // FIFO contents: CDB snoop of resident entries, pop at head, push at tail.
   // Push only happens when not full, so the tail slot is never the popped head.
   always_comb begin
      ent_d = ent_q;
      vld_d = vld_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i] && bus.cdb_valid && bus.cdb_tag != 4'd0) begin
            if (ent_q[i].qj == bus.cdb_tag) begin
               ent_d[i].vj = bus.cdb_value;
               ent_d[i].qj = 4'd0;
            end
            if (ent_q[i].qk == bus.cdb_tag) begin
               ent_d[i].vk = bus.cdb_value;
               ent_d[i].qk = 4'd0;
            end
         end
      end
      if (pop)
         vld_d[head_q] = 1'b0;
      if (accept) begin
         ent_d[tail_q] = new_e;
         vld_d[tail_q] = 1'b1;
      end
   end

   // Power-of-two depth: pointers wrap naturally.
   assign head_d = head_q + PW'(pop);
   assign tail_d = tail_q + PW'(accept);
   assign cnt_d  = cnt_q + CW'(accept) - CW'(pop);

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (hd_ready) state_d = S_REQ;
         S_REQ:   state_d = S_WAIT;
         S_WAIT: begin
            if (bus.V_pronto)
               state_d = hd.op[0] ? S_IDLE : S_BCAST;
            else if (timeout)
               state_d = S_IDLE;   // head stays put and is re-requested
         end
         S_BCAST: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic: next values of the registered memory/result outputs
   always_comb begin
      A_d         = A_q;
      data_d      = data_q;
      W_d         = W_q;
      op_d        = op_q;
      nova_d      = 1'b0;
      rdata_d     = rdata_q;
      res_valid_d = 1'b0;
      res_tag_d   = res_tag_q;
      res_value_d = res_value_q;
      if (state_q == S_IDLE && hd_ready) begin
         A_d    = hd.vj[7:0];
         data_d = hd.vk;
         W_d    = hd.op[0];
         op_d   = hd.op;
         nova_d = 1'b1;
      end
      if (state_q == S_WAIT && bus.V_pronto && !hd.op[0])
         rdata_d = bus.mem_out;
      if (state_q == S_BCAST) begin
         res_valid_d = 1'b1;
         res_tag_d   = hd.tag;
         res_value_d = rdata_q;
      end
   end

   // State register and registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         vld_q       <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         cnt_q       <= '0;
         A_q         <= '0;
         data_q      <= '0;
         W_q         <= 1'b0;
         op_q        <= '0;
         nova_q      <= 1'b0;
         rdata_q     <= '0;
         res_valid_q <= 1'b0;
         res_tag_q   <= '0;
         res_value_q <= '0;
      end else begin
         state_q     <= state_d;
         vld_q       <= vld_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         cnt_q       <= cnt_d;
         A_q         <= A_d;
         data_q      <= data_d;
         W_q         <= W_d;
         op_q        <= op_d;
         nova_q      <= nova_d;
         rdata_q     <= rdata_d;
         res_valid_q <= res_valid_d;
         res_tag_q   <= res_tag_d;
         res_value_q <= res_value_d;
      end
   end

   // Entry payload needs no reset; the valid bits qualify it.
   always_ff @(posedge clock) begin
      for (int i = 0; i < DEPTH; i++)
         ent_q[i] <= ent_d[i];
   end

   assign bus.full       = full;
   assign bus.A          = A_q;
   assign bus.data       = data_q;
   assign bus.W          = W_q;
   assign bus.opcode_out = op_q;
   assign bus.nova       = nova_q;
   assign bus.res_valid  = res_valid_q;
   assign bus.res_tag    = res_tag_q;
   assign bus.res_value  = res_value_q;
endmodule

// File: tb/tb_buffer_mem.sv
// tb_buffer_mem -- directed, table-driven bench for buffer_mem (DEPTH=4).
module tb_buffer_mem;
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   buffer_mem_if bus ();
   buffer_mem #(.DEPTH(4)) dut (.clock(clock), .reset(reset), .bus(bus));

   int checks = 0;
   int errors = 0;

   // Memory model / monitor state
   logic        mem_en    = 1'b0;
   logic        pulse_req = 1'b0;
   logic        nova_seen = 1'b0;
   logic [15:0] mem_rdata = 16'h0;
   int          cyc = 0;
   int          nova_cnt = 0, nova_cyc = 0, res_cnt = 0, res_cyc = 0;
   logic [7:0]  l_A;
   logic [15:0] l_D;
   logic        l_W;
   logic [1:0]  l_op;
   logic [3:0]  res_tags [$];
   logic [15:0] res_vals [$];

   typedef struct {
      logic [1:0]  op;
      logic [3:0]  tag;
      logic [15:0] vj;
      logic [15:0] mem;
      logic [7:0]  exp_a;
      logic [15:0] exp_val;
   } vec_t;
   vec_t vecs [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor samples 1 time unit after each rising edge; memory answers one
   // cycle after it sampled nova high.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         cyc++;
         if (bus.nova === 1'b1) begin
            nova_cnt++; nova_cyc = cyc;
            l_A = bus.A; l_D = bus.data; l_W = bus.W; l_op = bus.opcode_out;
         end
         if (bus.res_valid === 1'b1) begin
            res_cnt++; res_cyc = cyc;
            res_tags.push_back(bus.res_tag);
            res_vals.push_back(bus.res_value);
         end
         bus.V_pronto = (mem_en && nova_seen) || pulse_req;
         pulse_req    = 1'b0;
         bus.mem_out  = mem_rdata;
         nova_seen    = bus.nova;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic issue(input logic [1:0] op, input logic [3:0] tag, input logic [15:0] vj,
                        input logic [3:0] qj, input logic [15:0] vk, input logic [3:0] qk);
      @(negedge clock);
      bus.issue_opcode = op; bus.issue_tag = tag;
      bus.issue_Vj = vj; bus.issue_Qj = qj; bus.issue_Vk = vk; bus.issue_Qk = qk;
      bus.issue_valid = 1'b1;
      @(negedge clock);
      bus.issue_valid = 1'b0;
   endtask

   task automatic wait_res(input int n, input string name);
      int k = 0;
      while (res_cnt < n && k < 40) begin @(negedge clock); k++; end
      if (res_cnt < n) chk(name, 32'(res_cnt), 32'(n));
   endtask

   task automatic wait_nova(input int n, input string name);
      int k = 0;
      while (nova_cnt < n && k < 40) begin @(negedge clock); k++; end
      if (nova_cnt < n) chk(name, 32'(nova_cnt), 32'(n));
   endtask

   initial begin
      int nb, rb;
      vecs[0] = '{op: 2'b00, tag: 4'd5, vj: 16'h0012, mem: 16'hBEEF, exp_a: 8'h12, exp_val: 16'hBEEF};
      vecs[1] = '{op: 2'b10, tag: 4'd9, vj: 16'h1234, mem: 16'h0001, exp_a: 8'h34, exp_val: 16'h0001};
      vecs[2] = '{op: 2'b00, tag: 4'hF, vj: 16'hFFFF, mem: 16'h0000, exp_a: 8'hFF, exp_val: 16'h0000};
      vecs[3] = '{op: 2'b10, tag: 4'd1, vj: 16'h0080, mem: 16'hA5A5, exp_a: 8'h80, exp_val: 16'hA5A5};

      bus.issue_valid = 0; bus.issue_opcode = 0; bus.issue_tag = 0;
      bus.issue_Vj = 0; bus.issue_Qj = 0; bus.issue_Vk = 0; bus.issue_Qk = 0;
      bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_value = 0;
      bus.V_pronto = 0; bus.mem_out = 0;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      // Reset state
      chk("rst_full", bus.full, 0);
      chk("rst_nova", bus.nova, 0);
      chk("rst_W", bus.W, 0);
      chk("rst_res_valid", bus.res_valid, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_A", bus.A, 0);
      chk("rst_data", bus.data, 0);
      chk("rst_res_tag", bus.res_tag, 0);
      chk("rst_res_value", bus.res_value, 0);
      chk("rst_opcode_out", bus.opcode_out, 0);

      // Table: single loads through the full request/response path
      mem_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         nb = nova_cnt; rb = res_cnt;
         mem_rdata = vecs[i].mem;
         issue(vecs[i].op, vecs[i].tag, vecs[i].vj, 4'd0, 16'h0, 4'd0);
         wait_res(rb + 1, "ld_timeout");
         repeat (3) @(negedge clock);
         chk("ld_nova_cnt", 32'(nova_cnt - nb), 1);
         chk("ld_A", l_A, vecs[i].exp_a);
         chk("ld_W", l_W, 0);
         chk("ld_opcode", l_op, vecs[i].op);
         chk("ld_res_cnt", 32'(res_cnt - rb), 1);
         chk("ld_res_tag", res_tags[rb], vecs[i].tag);
         chk("ld_res_value", res_vals[rb], vecs[i].exp_val);
         chk("ld_latency", 32'(res_cyc - nova_cyc), 3);
      end

      // Store waiting on Qk, released by a CDB broadcast
      nb = nova_cnt; rb = res_cnt;
      issue(2'b01, 4'd2, 16'h0020, 4'd0, 16'h0000, 4'd3);
      repeat (5) @(negedge clock);
      chk("st_no_nova_before_cdb", 32'(nova_cnt - nb), 0);
      bus.cdb_valid = 1; bus.cdb_tag = 4'd3; bus.cdb_value = 16'h00AA;
      @(negedge clock);
      bus.cdb_valid = 0;
      wait_nova(nb + 1, "st_nova_timeout");
      repeat (5) @(negedge clock);
      chk("st_nova_cnt", 32'(nova_cnt - nb), 1);
      chk("st_A", l_A, 8'h20);
      chk("st_W", l_W, 1);
      chk("st_data", l_D, 16'h00AA);
      chk("st_no_res", 32'(res_cnt - rb), 0);
      chk("st_full", bus.full, 0);

      // Fill to DEPTH with memory silent; 5th issue dropped; in-order completion
      mem_en = 1'b0; mem_rdata = 16'h1111;
      nb = nova_cnt; rb = res_cnt;
      for (int t = 1; t <= 3; t++) begin
         issue(2'b00, 4'(t), 16'(t), 4'd0, 16'h0, 4'd0);
         chk("fill_not_full", bus.full, 0);
      end
      issue(2'b00, 4'd4, 16'h0004, 4'd0, 16'h0, 4'd0);
      chk("fill_full", bus.full, 1);
      issue(2'b00, 4'd5, 16'h0005, 4'd0, 16'h0, 4'd0);
      chk("fill_full_after_drop", bus.full, 1);
`ifndef BUFFER_MEM_TIMEOUT_EN
      chk("fill_one_request", 32'(nova_cnt - nb), 1);
`endif
      @(negedge clock);
      pulse_req = 1'b1;
      mem_en = 1'b1;
      wait_res(rb + 4, "fill_timeout");
      repeat (10) @(negedge clock);
      chk("fill_res_cnt", 32'(res_cnt - rb), 4);
      for (int t = 0; t < 4; t++)
         chk("fill_order", res_tags[rb + t], 4'(t + 1));
      chk("fill_drained", bus.full, 0);

      // Issue with Qj resolved by a same-cycle CDB broadcast
      nb = nova_cnt; rb = res_cnt; mem_rdata = 16'h7777;
      @(negedge clock);
      bus.issue_opcode = 2'b00; bus.issue_tag = 4'd8; bus.issue_Vj = 16'h0000;
      bus.issue_Qj = 4'd7; bus.issue_Vk = 16'h0; bus.issue_Qk = 4'd0; bus.issue_valid = 1;
      bus.cdb_valid = 1; bus.cdb_tag = 4'd7; bus.cdb_value = 16'h0040;
      @(negedge clock);
      bus.issue_valid = 0; bus.cdb_valid = 0;
      wait_res(rb + 1, "fwd_timeout");
      repeat (2) @(negedge clock);
      chk("fwd_A", l_A, 8'h40);
      chk("fwd_res_tag", res_tags[rb], 4'd8);
      chk("fwd_res_value", res_vals[rb], 16'h7777);

      // Reset while waiting on memory; late V_pronto must be ignored
      mem_en = 1'b0;
      nb = nova_cnt; rb = res_cnt;
      issue(2'b00, 4'd4, 16'h0033, 4'd0, 16'h0, 4'd0);
      wait_nova(nb + 1, "rstw_nova_timeout");
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("rstw_nova", bus.nova, 0);
      chk("rstw_A", bus.A, 0);
      chk("rstw_full", bus.full, 0);
      pulse_req = 1'b1;
      repeat (6) @(negedge clock);
      chk("rstw_no_res", 32'(res_cnt - rb), 0);
      chk("rstw_no_new_nova", 32'(nova_cnt - nb), 1);
      mem_en = 1'b1; mem_rdata = 16'h5A5A;
      issue(2'b00, 4'd6, 16'h0044, 4'd0, 16'h0, 4'd0);
      wait_res(rb + 1, "rstw_after_timeout");
      repeat (3) @(negedge clock);
      chk("rstw_after_cnt", 32'(res_cnt - rb), 1);
      chk("rstw_after_tag", res_tags[rb], 4'd6);
      chk("rstw_after_value", res_vals[rb], 16'h5A5A);

`ifdef BUFFER_MEM_TIMEOUT_EN
      // Memory never answers: err rises and the head is requested again
      mem_en = 1'b0; mem_rdata = 16'h0BAD;
      nb = nova_cnt; rb = res_cnt;
      issue(2'b00, 4'd3, 16'h0007, 4'd0, 16'h0, 4'd0);
      wait_nova(nb + 2, "to_reissue_timeout");
      chk("to_err", bus.err, 1);
      chk("to_nova_cnt", 32'(nova_cnt - nb), 2);
      chk("to_A", l_A, 8'h07);
      @(negedge clock);
      pulse_req = 1'b1;
      mem_en = 1'b1;
      wait_res(rb + 1, "to_done_timeout");
      repeat (2) @(negedge clock);
      chk("to_res_value", res_vals[rb], 16'h0BAD);
      chk("to_err_sticky", bus.err, 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
